// File: rtl/braille_encoder.sv
// braille_encoder
//   Collects ASCII characters into a cell buffer, translating each into one
//   or two six-dot Braille cells, then plays the buffered cells out as a
//   burst once the final character of a message arrives.
//
//   Parameters
//     MAX_CELLS     cell buffer depth (2..255)
//   Optional build macro
//     CAPITAL_SIGN_EN  prefix uppercase letters with the capital sign (0x20)
//   Ports
//     clk           single clock, rising edge
//     reset         synchronous active-high reset
//     ascii_in      character code, qualified by ascii_valid
//     ascii_valid   character strobe
//     ascii_last    final character of the message (sampled with ascii_valid)
//     ascii_ready   high in IDLE/COLLECT, low while a burst is emitted
//     braille_out   cell, bit n-1 = dot n, bits [7:6] = 0
//     braille_size  number of cells in the current / last burst
//     braille_valid qualifies braille_out
//     overflow      sticky: a character was dropped for lack of room
module braille_encoder #(
    parameter int MAX_CELLS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    input  logic       ascii_last,
    output logic       ascii_ready,
    output logic [7:0] braille_out,
    output logic [7:0] braille_size,
    output logic       braille_valid,
    output logic       overflow
);

    localparam int IDX_W = $clog2(MAX_CELLS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    localparam logic [5:0] NUM_SIGN = 6'h3C;
    localparam logic [5:0] CAP_SIGN = 6'h20;

    logic [1:0]       state_q,  state_d;
    logic [7:0]       count_q,  count_d;
    logic             run_q,    run_d;
    logic             ovf_q,    ovf_d;
    logic [7:0]       size_q,   size_d;
    logic [7:0]       rd_idx_q, rd_idx_d;
    logic [5:0]       cells_q [MAX_CELLS];
    logic [5:0]       cells_d [MAX_CELLS];

    logic             is_lower, is_upper, is_digit;
    logic [1:0]       enc_n;
    logic [5:0]       enc_c0, enc_c1, digit_cell;
    logic [7:0]       base_count;
    logic             base_run;
    logic [8:0]       need;
    logic             fit;
    logic [IDX_W-1:0] wr0, wr1, rd_sl;

    // Cell for the idx-th letter of the alphabet (0 = 'a').
    function automatic logic [5:0] letter_cell(input logic [4:0] idx);
        case (idx)
            5'd0:  letter_cell = 6'h01;  5'd1:  letter_cell = 6'h03;
            5'd2:  letter_cell = 6'h09;  5'd3:  letter_cell = 6'h19;
            5'd4:  letter_cell = 6'h11;  5'd5:  letter_cell = 6'h0B;
            5'd6:  letter_cell = 6'h1B;  5'd7:  letter_cell = 6'h13;
            5'd8:  letter_cell = 6'h0A;  5'd9:  letter_cell = 6'h1A;
            5'd10: letter_cell = 6'h05;  5'd11: letter_cell = 6'h07;
            5'd12: letter_cell = 6'h0D;  5'd13: letter_cell = 6'h1D;
            5'd14: letter_cell = 6'h15;  5'd15: letter_cell = 6'h0F;
            5'd16: letter_cell = 6'h1F;  5'd17: letter_cell = 6'h17;
            5'd18: letter_cell = 6'h0E;  5'd19: letter_cell = 6'h1E;
            5'd20: letter_cell = 6'h25;  5'd21: letter_cell = 6'h27;
            5'd22: letter_cell = 6'h3A;  5'd23: letter_cell = 6'h2D;
            5'd24: letter_cell = 6'h3D;  5'd25: letter_cell = 6'h35;
            default: letter_cell = 6'h3F;
        endcase
    endfunction

    function automatic logic [5:0] punct_cell(input logic [7:0] ch);
        case (ch)
            8'h20:   punct_cell = 6'h00;  // space
            8'h2C:   punct_cell = 6'h02;  // ,
            8'h2E:   punct_cell = 6'h32;  // .
            8'h3F:   punct_cell = 6'h26;  // ?
            8'h21:   punct_cell = 6'h16;  // !
            default: punct_cell = 6'h3F;
        endcase
    endfunction

    assign ascii_ready   = (state_q != S_EMIT);
    assign braille_valid = (state_q == S_EMIT);
    assign rd_sl         = rd_idx_q[IDX_W-1:0];
    assign braille_out   = braille_valid ? {2'b00, cells_q[rd_sl]} : 8'h00;
    assign braille_size  = size_q;
    assign overflow      = ovf_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        run_d    = run_q;
        ovf_d    = ovf_q;
        size_d   = size_q;
        rd_idx_d = rd_idx_q;
        cells_d  = cells_q;

        is_lower = (ascii_in >= 8'h61) && (ascii_in <= 8'h7A);
        is_upper = (ascii_in >= 8'h41) && (ascii_in <= 8'h5A);
        is_digit = (ascii_in >= 8'h30) && (ascii_in <= 8'h39);

        // A message starting in IDLE sees a fresh buffer and no digit run.
        base_count = (state_q == S_IDLE) ? 8'd0 : count_q;
        base_run   = (state_q == S_IDLE) ? 1'b0 : run_q;

        // '0' takes cell j; '1'..'9' take cells a..i.
        digit_cell = (ascii_in[3:0] == 4'd0) ? 6'h1A
                                             : letter_cell({1'b0, ascii_in[3:0] - 4'd1});

        enc_n  = 2'd1;
        enc_c0 = punct_cell(ascii_in);
        enc_c1 = 6'h00;
        if (is_lower) begin
            enc_c0 = letter_cell(ascii_in[4:0] - 5'd1);
        end else if (is_upper) begin
`ifdef CAPITAL_SIGN_EN
            enc_n  = 2'd2;
            enc_c0 = CAP_SIGN;
            enc_c1 = letter_cell(ascii_in[4:0] - 5'd1);
`else
            enc_c0 = letter_cell(ascii_in[4:0] - 5'd1);
`endif
        end else if (is_digit) begin
            if (base_run) begin
                enc_c0 = digit_cell;
            end else begin
                enc_n  = 2'd2;
                enc_c0 = NUM_SIGN;
                enc_c1 = digit_cell;
            end
        end

        need = {1'b0, base_count} + {7'd0, enc_n};
        fit  = (need <= 9'(MAX_CELLS));
        wr0  = base_count[IDX_W-1:0];
        wr1  = wr0 + IDX_W'(1);

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (ascii_valid) begin
                    count_d = base_count;
                    run_d   = base_run;
                    ovf_d   = (state_q == S_IDLE) ? 1'b0 : ovf_q;
                    if (fit) begin
                        cells_d[wr0] = enc_c0;
                        if (enc_n == 2'd2) begin
                            cells_d[wr1] = enc_c1;
                        end
                        count_d = need[7:0];
                        run_d   = is_digit;
                    end else begin
                        // Dropped whole; the digit run is left as it was.
                        ovf_d = 1'b1;
                    end
                    if (ascii_last) begin
                        state_d  = S_EMIT;
                        size_d   = count_d;
                        rd_idx_d = 8'd0;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_EMIT: begin
                rd_idx_d = rd_idx_q + 8'd1;
                if ((count_q == 8'd0) || (rd_idx_q == count_q - 8'd1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= 8'd0;
            run_q    <= 1'b0;
            ovf_q    <= 1'b0;
            size_q   <= 8'd0;
            rd_idx_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            run_q    <= run_d;
            ovf_q    <= ovf_d;
            size_q   <= size_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Cell storage carries no reset; only cells below count are ever read.
    always_ff @(posedge clk) begin
        cells_q <= cells_d;
    end

endmodule
